// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: buffers ALU commands, drives registered operands onto the ALU pins, waits SETTLE_CYCLES, returns C/V in command order; optional result chaining under `ALU_SEQ_CHAIN_EN
module alu_op_sequencer #(
  parameter int FIFO_DEPTH    = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic       cmd_chain,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       Op0,
  output logic       Op1,
  input  logic [3:0] C,
  input  logic       V,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_c,
  output logic       rsp_v,
  output logic       busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
`ifdef ALU_SEQ_CHAIN_EN
  localparam int EW = 11;
`else
  localparam int EW = 10;
`endif
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
  state_t        r_state, w_next;
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [EW-1:0] w_wdata, w_head;
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;
  logic [CW-1:0] r_cnt;
  logic          r_up, w_full, w_empty, w_push, w_pop, w_sample;
  logic [3:0]    w_a_load;
`ifdef ALU_SEQ_CHAIN_EN
  logic [3:0]    r_last;
  assign w_wdata  = {cmd_chain, cmd_op, cmd_a, cmd_b};
  assign w_a_load = w_head[10] ? r_last : w_head[7:4];
`else
  logic          w_unused;
  assign w_unused = cmd_chain;
  assign w_wdata  = {cmd_op, cmd_a, cmd_b};
  assign w_a_load = w_head[7:4];
`endif
  assign w_head    = r_mem[r_rd];
  assign w_full    = r_count == (AW+1)'(FIFO_DEPTH);
  assign w_empty   = r_count == '0;
  // r_up keeps ready low until the first edge out of reset
  assign cmd_ready = r_up && !w_full;
  assign w_push    = cmd_valid && cmd_ready;
  assign busy      = (r_state != IDLE) || !w_empty;
  // next state: pop in IDLE or on a completed response, sample when the settle count expires
  always_comb begin
    w_next   = r_state;
    w_pop    = 1'b0;
    w_sample = 1'b0;
    unique case (r_state)
      IDLE: if (!w_empty) begin
        w_pop  = 1'b1;
        w_next = SETTLE;
      end
      SETTLE: if (r_cnt == CW'(1)) begin
        w_sample = 1'b1;
        w_next   = HOLD;
      end
      HOLD: if (rsp_ready) begin
        w_pop  = !w_empty;
        w_next = w_empty ? IDLE : SETTLE;
      end
      default: w_next = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // command storage; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_wdata;
  end
  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_up    <= 1'b0;
    end else begin
      r_up    <= 1'b1;
      r_wr    <= w_push ? r_wr + AW'(1) : r_wr;
      r_rd    <= w_pop ? r_rd + AW'(1) : r_rd;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  // ALU pin drive, settle counter and response capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      A         <= '0;
      B         <= '0;
      Op0       <= 1'b0;
      Op1       <= 1'b0;
      r_cnt     <= '0;
      rsp_valid <= 1'b0;
      rsp_c     <= '0;
      rsp_v     <= 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
      r_last    <= '0;
`endif
    end else begin
      if (w_pop) begin
        A          <= w_a_load;
        B          <= w_head[3:0];
        {Op1, Op0} <= w_head[9:8];
        r_cnt      <= CW'(SETTLE_CYCLES);
      end else if (r_state == SETTLE) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_sample) begin
        rsp_c     <= C;
        rsp_v     <= V;
        rsp_valid <= 1'b1;
      end else if (r_state == HOLD && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
`ifdef ALU_SEQ_CHAIN_EN
      if (w_sample) r_last <= C;
`endif
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: table vectors, hand sequences and random traffic against a queue-based result model
module tb_alu_op_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, rst3_n, sel3;
  logic       cmd_valid, cmd_chain, rsp_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_a, cmd_b;
  logic       cv1, cv3, w_rdy;
  logic       cmd_ready, Op0, Op1, V, rsp_valid, rsp_v, busy;
  logic [3:0] A, B, C, rsp_c;
  logic       cmd_ready3, Op03, Op13, V3, rsp_valid3, rsp_v3, busy3;
  logic [3:0] A3, B3, C3, rsp_c3;
  int         n_checks = 0, n_fail = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  logic [3:0] got3_q[$];
  logic [3:0] last_m;

  always #5 clk = ~clk;

  // external 4-bit ALU: 00 nand, 01 A-B, 10 nor, 11 A+B; V is signed overflow
  function automatic logic [4:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    logic [3:0] s;
    logic v;
    v = 1'b0;
    case (op)
      2'd0: s = ~(a & b);
      2'd1: begin s = a - b; v = (a[3] != b[3]) && (s[3] != a[3]); end
      2'd2: s = ~(a | b);
      default: begin s = a + b; v = (a[3] == b[3]) && (s[3] != a[3]); end
    endcase
    return {v, s};
  endfunction

  assign {V, C}   = alu(A, B, {Op1, Op0});
  assign {V3, C3} = alu(A3, B3, {Op13, Op03});
  assign cv1      = cmd_valid && !sel3;
  assign cv3      = cmd_valid && sel3;
  assign w_rdy    = sel3 ? cmd_ready3 : cmd_ready;

  alu_op_sequencer #(.FIFO_DEPTH(2), .SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cv1), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain), .A(A), .B(B), .Op0(Op0), .Op1(Op1),
    .C(C), .V(V), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c), .rsp_v(rsp_v), .busy(busy));

  alu_op_sequencer #(.FIFO_DEPTH(2), .SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .cmd_valid(cv3), .cmd_ready(cmd_ready3), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain), .A(A3), .B(B3), .Op0(Op03), .Op1(Op13),
    .C(C3), .V(V3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_c(rsp_c3), .rsp_v(rsp_v3), .busy(busy3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b, input logic ch);
    int t = 0;
    logic acc;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = ch;
    do begin
      acc = w_rdy;
      tick();
      t++;
    end while (!acc && t < 200);
    cmd_valid = 1'b0;
    chk("push_accept", acc, 1);
  endtask

  task automatic wait_got(input int n);
    int t = 0;
    while (got_q.size() < n && t < 500) begin tick(); t++; end
    chk("rsp_count", got_q.size(), n);
  endtask

  // reference model: results predicted in command order at acceptance, checked at each response handshake
  always @(negedge clk) begin
    logic [8:0] e;
    logic [3:0] ae;
    logic [4:0] r;
    if (!rst_n) begin
      exp_q.delete();
      last_m = '0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        got_q.push_back({A, rsp_v, rsp_c});
        chk("rsp_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("model_c", rsp_c, e[3:0]);
          chk("model_v", rsp_v, e[4]);
          chk("model_a", A, e[8:5]);
        end
      end
      if (cv1 && cmd_ready) begin
        ae = cmd_a;
`ifdef ALU_SEQ_CHAIN_EN
        if (cmd_chain) ae = last_m;
`endif
        r = alu(ae, cmd_b, cmd_op);
        last_m = r[3:0];
        exp_q.push_back({ae, r});
      end
    end
  end

  always @(negedge clk) if (rst3_n && rsp_valid3 && rsp_ready) got3_q.push_back(rsp_c3);

  typedef struct {
    logic [1:0] op;
    logic [3:0] a, b, c;
    logic       v;
  } vec_t;

  initial begin
    vec_t tbl[9];
    int n0, t;
    logic saw, done;
    tbl[0] = '{2'd0, 4'hF, 4'hF, 4'h0, 1'b0};
    tbl[1] = '{2'd0, 4'h5, 4'h3, 4'hE, 1'b0};
    tbl[2] = '{2'd1, 4'h3, 4'h5, 4'hE, 1'b0};
    tbl[3] = '{2'd1, 4'h8, 4'h1, 4'h7, 1'b1};
    tbl[4] = '{2'd2, 4'hA, 4'h5, 4'h0, 1'b0};
    tbl[5] = '{2'd2, 4'h1, 4'h2, 4'hC, 1'b0};
    tbl[6] = '{2'd3, 4'h7, 4'h1, 4'h8, 1'b1};
    tbl[7] = '{2'd3, 4'hF, 4'h1, 4'h0, 1'b0};
    tbl[8] = '{2'd3, 4'h4, 4'h4, 4'h8, 1'b1};
    rst_n = 1'b0; rst3_n = 1'b0; sel3 = 1'b0; rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_a = 4'h9; cmd_b = 4'h9; cmd_chain = 1'b0;
    repeat (3) tick();
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_op", {Op1, Op0}, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    rst_n = 1'b1; cmd_valid = 1'b0;
    tick();
    chk("rel_cmd_ready", cmd_ready, 1);
    chk("rel_busy", busy, 0);
    // single op latency
    rsp_ready = 1'b1;
    push(2'd3, 4'h3, 4'h4, 1'b0);
    tick();
    chk("lat_A", A, 3);
    chk("lat_B", B, 4);
    chk("lat_op", {Op1, Op0}, 3);
    chk("lat_valid_k1", rsp_valid, 0);
    tick();
    chk("lat_valid_k2", rsp_valid, 1);
    chk("lat_c", rsp_c, 7);
    chk("lat_v", rsp_v, 0);
    tick();
    chk("lat_valid_k3", rsp_valid, 0);
    chk("lat_busy", busy, 0);
    // overflow pair in order
    n0 = got_q.size();
    push(2'd3, 4'h7, 4'h1, 1'b0);
    push(2'd1, 4'h8, 4'h1, 1'b0);
    wait_got(n0 + 2);
    chk("ovf0_c", got_q[n0][3:0], 8);
    chk("ovf0_v", got_q[n0][4], 1);
    chk("ovf1_c", got_q[n0+1][3:0], 7);
    chk("ovf1_v", got_q[n0+1][4], 1);
    // table vectors
    for (int i = 0; i < 9; i++) begin
      n0 = got_q.size();
      push(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0);
      wait_got(n0 + 1);
      chk($sformatf("tbl%0d_c", i), got_q[n0][3:0], tbl[i].c);
      chk($sformatf("tbl%0d_v", i), got_q[n0][4], tbl[i].v);
    end
    // backpressure and full FIFO
    rsp_ready = 1'b0;
    n0 = got_q.size();
    push(2'd0, 4'hF, 4'hF, 1'b0);
    push(2'd2, 4'h0, 4'h0, 1'b0);
    push(2'd3, 4'h1, 4'h1, 1'b0);
    fork
      push(2'd3, 4'h2, 4'h2, 1'b0);
      begin
        repeat (3) tick();
        chk("bp_cmd_ready", cmd_ready, 0);
        chk("bp_rsp_valid", rsp_valid, 1);
        chk("bp_rsp_c", rsp_c, 0);
        chk("bp_busy", busy, 1);
        chk("bp_no_rsp", got_q.size(), n0);
        rsp_ready = 1'b1;
      end
    join
    wait_got(n0 + 4);
    chk("bp0", got_q[n0][3:0], 4'h0);
    chk("bp1", got_q[n0+1][3:0], 4'hF);
    chk("bp2", got_q[n0+2][3:0], 4'h2);
    chk("bp3", got_q[n0+3][3:0], 4'h4);
    // reset during SETTLE on the SETTLE_CYCLES=3 instance
    sel3 = 1'b1; rst3_n = 1'b1;
    tick();
    push(2'd3, 4'h1, 4'h1, 1'b0);
    tick();
    tick();
    rst3_n = 1'b0;
    tick();
    rst3_n = 1'b1;
    chk("mid_busy", busy3, 0);
    saw = 1'b0;
    repeat (6) begin saw = saw | rsp_valid3; tick(); end
    chk("mid_no_valid", saw, 0);
    chk("mid_no_rsp", got3_q.size(), 0);
    push(2'd3, 4'h2, 4'h2, 1'b0);
    t = 0;
    while (got3_q.size() < 1 && t < 100) begin tick(); t++; end
    chk("mid_rsp_count", got3_q.size(), 1);
    if (got3_q.size() != 0) chk("mid_after_c", got3_q[0], 4);
    sel3 = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
    n0 = got_q.size();
    push(2'd3, 4'h5, 4'h2, 1'b0);
    push(2'd1, 4'hF, 4'h3, 1'b1);
    wait_got(n0 + 2);
    chk("chain0_c", got_q[n0][3:0], 7);
    chk("chain1_c", got_q[n0+1][3:0], 4);
    chk("chain1_A", got_q[n0+1][8:5], 7);
`endif
    // random traffic with random response backpressure
    n0 = got_q.size();
    done = 1'b0;
    fork
      while (!done) begin rsp_ready = 1'($urandom_range(0, 1)); tick(); end
      begin
        for (int i = 0; i < 40; i++)
          push(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
        done = 1'b1;
      end
    join
    rsp_ready = 1'b1;
    wait_got(n0 + 40);
    tick();
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end
endmodule
